// File: rtl/queue_reverse_pkg.sv
// queue_reverse_pkg: shared types and sizing helpers for the queue_reverse stage
package queue_reverse_pkg;
  typedef enum logic {FILL, DRAIN} state_t;
  localparam int W_DATA_DEF = 16;
  localparam int EOT_BIT = W_DATA_DEF;
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/lifo_mem.sv
// lifo_mem: DEPTH x W register array, one sync write port, one async read port, no reset
//   clk            clock
//   we/waddr/wdata write enable, address, data
//   raddr/rdata    combinational read
module lifo_mem #(
  parameter int W = 16,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/queue_reverse.sv
// queue_reverse: buffers one eot-terminated transaction and replays it last-to-first
//   clk, rst                      clock, synchronous active-high reset
//   din_valid/din_ready/din_data  upstream element, din_data[W_DATA] = eot
//   dout_valid/dout_ready/dout_data downstream element, eot re-attached to final element
//   ovf                           sticky forced-close flag (only with QUEUE_REVERSE_OVF_EN)
module queue_reverse
  import queue_reverse_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [W_DATA:0] din_data,
  input  logic            dout_ready,
  output logic            dout_valid,
  output logic [W_DATA:0] dout_data
`ifdef QUEUE_REVERSE_OVF_EN
  ,
  output logic            ovf
`endif
);
  localparam int CW = cnt_width(DEPTH);
  localparam int AW = $clog2(DEPTH);
  // eot travels just above the payload
  localparam int EB = W_DATA;
  state_t r_state, w_next_state;
  logic [CW-1:0] r_cnt, w_next_cnt;
  logic w_in_hs, w_out_hs, w_full;
  logic [W_DATA-1:0] w_rdata;
  // handshake flags come from registered state only; rst masks them during reset
  assign din_ready  = (r_state == FILL) && !rst;
  assign dout_valid = (r_state == DRAIN) && !rst;
  assign w_in_hs    = din_valid && din_ready;
  assign w_out_hs   = dout_valid && dout_ready;
  // writing the last slot closes the chunk even without eot
  assign w_full     = r_cnt == CW'(DEPTH - 1);
  assign dout_data  = {r_cnt == CW'(1), w_rdata};
  always_comb begin
    w_next_cnt   = w_in_hs ? r_cnt + CW'(1) : w_out_hs ? r_cnt - CW'(1) : r_cnt;
    w_next_state = (w_in_hs && (din_data[EB] || w_full)) ? DRAIN :
                   (w_out_hs && r_cnt == CW'(1)) ? FILL : r_state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
`ifdef QUEUE_REVERSE_OVF_EN
  always_ff @(posedge clk)
    if (rst) ovf <= 1'b0;
    else if (w_in_hs && !din_data[EB] && w_full) ovf <= 1'b1;
`endif
  lifo_mem #(.W(W_DATA), .DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (w_in_hs),
    .waddr(AW'(r_cnt)),
    .wdata(din_data[W_DATA-1:0]),
    .raddr(AW'(r_cnt - CW'(1))),
    .rdata(w_rdata)
  );
endmodule

// File: tb/tb_queue_reverse.sv
// tb_queue_reverse: table vectors, corner sequences and randomized traffic for queue_reverse
module tb_queue_reverse;
  localparam int W = 16;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst, din_valid, din_ready, dout_ready, dout_valid;
  logic [W:0] din_data, dout_data;
  int checks = 0;
  int errors = 0;
  logic [W:0] s_in[$];
  logic [W:0] s_exp[$];
`ifdef QUEUE_REVERSE_OVF_EN
  logic ovf;
  logic exp_ovf = 1'b0;
`endif
  always #5 clk = ~clk;

  queue_reverse #(.W_DATA(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din_data  (din_data),
    .dout_ready(dout_ready),
    .dout_valid(dout_valid),
    .dout_data (dout_data)
`ifdef QUEUE_REVERSE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    int           n;
    logic [127:0] din;
    int           m;
    logic [127:0] dout;
    logic [7:0]   dout_eot;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: split the stream into chunks closed by eot or by reaching D elements,
  // emit each chunk reversed with eot only on its final output element.
  function automatic void build_exp();
    logic [W:0] ch[$];
    s_exp.delete();
    foreach (s_in[k]) begin
      ch.push_back(s_in[k]);
      if (s_in[k][W] || ch.size() == D) begin
        for (int j = ch.size() - 1; j >= 0; j--) s_exp.push_back({j == 0, ch[j][W-1:0]});
        ch.delete();
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; din_data = '0;
    #1;
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_din_ready", din_ready, 1);
    chk("post_rst_dout_valid", dout_valid, 0);
`ifdef QUEUE_REVERSE_OVF_EN
    exp_ovf = 1'b0;
    chk("post_rst_ovf", ovf, 0);
`endif
  endtask

  // Streams s_in with din_valid held high while data remains, checks s_exp in order,
  // plus stall stability, half-duplex, first-output latency and refill latency.
  task automatic run_stream(input int pct, input int max_out);
    int ii = 0, oi = 0, cyc = 0, cn = 0, close_at = -10, free_at = -10;
    logic stalled = 1'b0;
    logic [W:0] held = '0;
    while (oi < s_exp.size() && oi < max_out) begin
      @(negedge clk);
      din_valid = ii < s_in.size();
      din_data = din_valid ? s_in[ii] : '0;
      dout_ready = $urandom_range(99) < pct;
      #1;
      if (cyc == close_at + 1) chk("first_out_latency", dout_valid, 1);
      if (cyc == free_at + 1 && din_valid) chk("refill_latency", din_ready, 1);
      if (dout_valid) chk("no_input_in_drain", din_ready, 0);
      if (stalled && dout_valid) chk("stall_hold", dout_data, held);
      stalled = dout_valid && !dout_ready;
      held = dout_data;
      if (din_valid && din_ready) begin
        cn++;
        if (s_in[ii][W] || cn == D) begin
          close_at = cyc;
`ifdef QUEUE_REVERSE_OVF_EN
          if (!s_in[ii][W]) exp_ovf = 1'b1;
`endif
          cn = 0;
        end
        ii++;
      end
      if (dout_valid && dout_ready) begin
        chk("out_elem", dout_data, s_exp[oi]);
        if (s_exp[oi][W]) free_at = cyc;
        oi++;
      end
      if (++cyc > 3000) begin
        checks++; errors++;
        $display("FAIL timeout: got %0d outputs expected %0d", oi, s_exp.size());
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; din_data = '0;
    tv[0] = '{4, 128'h0004_0003_0002_0001, 4, 128'h0001_0002_0003_0004, 8'b0000_1000};
    tv[1] = '{1, 128'hABCD, 1, 128'hABCD, 8'b0000_0001};
    tv[2] = '{6, 128'h000F_000E_000D_000C_000B_000A, 6, 128'h000E_000F_000A_000B_000C_000D, 8'b0010_1000};
    tv[3] = '{2, 128'h0006_0005, 2, 128'h0005_0006, 8'b0000_0010};
    tv[4] = '{5, 128'h0005_0004_0003_0002_0001, 5, 128'h0005_0001_0002_0003_0004, 8'b0001_1000};
    do_reset();
    for (int v = 0; v < 5; v++) begin
      s_in.delete();
      s_exp.delete();
      for (int k = 0; k < tv[v].n; k++) s_in.push_back({k == tv[v].n - 1, tv[v].din[k*16 +: 16]});
      for (int k = 0; k < tv[v].m; k++) s_exp.push_back({tv[v].dout_eot[k], tv[v].dout[k*16 +: 16]});
      run_stream(100, 1000);
`ifdef QUEUE_REVERSE_OVF_EN
      chk("ovf_sticky", ovf, exp_ovf);
`endif
    end
    // back-to-back transactions with stalls on the output side
    s_in.delete();
    for (int k = 0; k < 5; k++) s_in.push_back({k == 4, 16'(16'h100 + k)});
    for (int k = 0; k < 3; k++) s_in.push_back({k == 2, 16'(16'h200 + k)});
    build_exp();
    run_stream(50, 1000);
    // reset in the middle of a drain discards the remaining element
    do_reset();
    s_in.delete();
    for (int k = 1; k <= 3; k++) s_in.push_back({k == 3, 16'(k)});
    build_exp();
    run_stream(100, 2);
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b1;
    #1;
    chk("mid_drain_rst_valid", dout_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_drain_rst_ready", din_ready, 1);
    chk("mid_drain_rst_no_out", dout_valid, 0);
`ifdef QUEUE_REVERSE_OVF_EN
    exp_ovf = 1'b0;
`endif
    s_in.delete();
    s_in.push_back({1'b0, 16'd7});
    s_in.push_back({1'b1, 16'd8});
    build_exp();
    run_stream(100, 1000);
    // randomized transactions, lengths spanning below, at and above D
    s_in.delete();
    for (int t = 0; t < 20; t++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) s_in.push_back({k == len - 1, 16'($urandom)});
    end
    build_exp();
    run_stream(50, 100000);
`ifdef QUEUE_REVERSE_OVF_EN
    chk("ovf_random", ovf, exp_ovf);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
